// File: rtl/inst_sram_responder.sv
// inst_sram_responder: in-order, fixed-latency sram-like bus slave over a word array
//   clk, reset      : clock; synchronous active-high reset
//   req/wen/addr/wdata : request from initiator (wen==0 means read)
//   addr_ok         : request accepted when req && addr_ok
//   data_ok/rdata   : one-cycle response pulse; rdata is 0 outside data_ok
//   Optional INST_SRAM_RAND_DELAY_EN: LFSR-driven random stalls on accept and response.
module inst_sram_responder #(
    parameter int LATENCY = 2,
    parameter int DEPTH = 2,
    parameter int MEM_AW = 14,
    parameter INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [3:0]  wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]   mem [2**MEM_AW];
    logic [31:0]   q_data [DEPTH];
    logic [3:0]    q_cd [DEPTH];
    logic [CW-1:0] count;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [MEM_AW-1:0] idx;
    logic push, pop, gate_ok, stall;
    logic unused_addr;

`ifdef INST_SRAM_RAND_DELAY_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk)
        lfsr <= reset ? 16'hACE1 : {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign gate_ok = lfsr[1:0] != 2'b00;
    assign stall   = lfsr[3:2] == 2'b00;
`else
    assign gate_ok = 1'b1;
    assign stall   = 1'b0;
`endif

    assign idx         = addr[MEM_AW+1:2];
    assign unused_addr = ^{addr[31:MEM_AW+2], addr[1:0]};
    assign addr_ok     = !reset && count < CW'(DEPTH) && gate_ok;
    assign data_ok     = !reset && count != '0 && q_cd[rd_ptr] == 4'd0 && !stall;
    assign rdata       = data_ok ? q_data[rd_ptr] : 32'h0;
    assign push        = req && addr_ok;
    assign pop         = data_ok;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Array write and read-sample share the accept edge, so a write response
    // carries the word as it was before the write.
    always_ff @(posedge clk) begin
        if (push) q_data[wr_ptr] <= mem[idx];
        for (int b = 0; b < 4; b++)
            if (push && wen[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) q_cd[i] <= 4'd0;
        end else begin
            count <= count + CW'(push) - CW'(pop);
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop) rd_ptr <= nxt(rd_ptr);
            // Every entry counts from its own push so a queued entry is ready on
            // promotion; only the head is held back by a stall.
            for (int i = 0; i < DEPTH; i++)
                if (push && wr_ptr == PW'(i)) q_cd[i] <= 4'(LATENCY - 1);
                else if (q_cd[i] != 4'd0 && !(stall && rd_ptr == PW'(i))) q_cd[i] <= q_cd[i] - 4'd1;
        end
    end
endmodule
